// File: rtl/imem_load_arbiter.sv
// Instruction-RAM arbiter: CPU fetch in RUN, byte-serial program loader otherwise.
// Define IMEM_LOAD_CHECKSUM_EN to add the XOR checksum trailer check (CHECK/ERR states).
module imem_load_arbiter #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [31:0]       cpu_addr,
  output logic [31:0]       cpu_instr,
  output logic              cpu_stall,
  output logic              pc_clear,
  output logic              fetch_fault,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              load_done,
  output logic              load_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    RUN,
    COLLECT,
    WRITE,
    DONE
`ifdef IMEM_LOAD_CHECKSUM_EN
    , CHECK
    , ERR
`endif
  } state_t;

  state_t          state;
  logic [ADDR_W:0] wcnt;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] len_in;
  logic [1:0]      bcnt;
  logic [23:0]     word;
  logic [31:0]     packed_word;
  logic            take;
  logic            start_ok;
  logic            unused_addr_hi;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]     chk;
`else
  assign load_err = 1'b0;
`endif

  // Length is clamped to the RAM depth so an oversized request fills the RAM exactly once.
  function automatic logic [ADDR_W:0] clamp_len(input logic [LEN_W-1:0] l);
    if (32'(l) > 32'(DEPTH)) return (ADDR_W+1)'(DEPTH);
    return (ADDR_W+1)'(l);
  endfunction

  assign unused_addr_hi = ^cpu_addr[31:ADDR_W+2];

  always_comb begin
    take        = byte_valid & byte_ready;
    packed_word = {word, byte_data};
    len_in      = clamp_len(load_len);
    start_ok    = load_start && (state == RUN);
`ifdef IMEM_LOAD_CHECKSUM_EN
    if (state == ERR) start_ok = load_start;
`endif
  end

  // Fetch path is combinational in RUN; while loading the read port follows the word counter.
  always_comb begin
    mem_raddr   = wcnt[ADDR_W-1:0];
    cpu_instr   = 32'd0;
    fetch_fault = 1'b0;
    if (state == RUN) begin
      mem_raddr   = cpu_addr[ADDR_W+1:2];
      fetch_fault = |cpu_addr[1:0];
      cpu_instr   = fetch_fault ? 32'd0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      wcnt       <= '0;
      len        <= '0;
      bcnt       <= 2'd0;
      word       <= 24'd0;
      byte_ready <= 1'b0;
      cpu_stall  <= 1'b0;
      pc_clear   <= 1'b0;
      load_done  <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= 32'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      chk        <= 32'd0;
      load_err   <= 1'b0;
`endif
    end else begin
      mem_we    <= 1'b0;
      pc_clear  <= 1'b0;
      load_done <= 1'b0;
      if (start_ok) begin
        wcnt      <= '0;
        bcnt      <= 2'd0;
        len       <= len_in;
        cpu_stall <= 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        chk       <= 32'd0;
        load_err  <= 1'b0;
`endif
        if (len_in == '0) begin
          state      <= DONE;
          load_done  <= 1'b1;
          pc_clear   <= 1'b1;
          byte_ready <= 1'b0;
        end else begin
          state      <= COLLECT;
          byte_ready <= 1'b1;
        end
      end else begin
        case (state)
          RUN: ;
          COLLECT: begin
            if (take) begin
              word <= packed_word[23:0];
              bcnt <= bcnt + 2'd1;
              if (bcnt == 2'd3) begin
                state      <= WRITE;
                byte_ready <= 1'b0;
                mem_we     <= 1'b1;
                mem_waddr  <= wcnt[ADDR_W-1:0];
                mem_wdata  <= packed_word;
`ifdef IMEM_LOAD_CHECKSUM_EN
                chk        <= chk ^ packed_word;
`endif
              end
            end
          end
          WRITE: begin
            wcnt <= wcnt + ONE;
            bcnt <= 2'd0;
            if (wcnt + ONE == len) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
              state      <= CHECK;
              byte_ready <= 1'b1;
`else
              state      <= DONE;
              load_done  <= 1'b1;
              pc_clear   <= 1'b1;
`endif
            end else begin
              state      <= COLLECT;
              byte_ready <= 1'b1;
            end
          end
`ifdef IMEM_LOAD_CHECKSUM_EN
          CHECK: begin
            if (take) begin
              word <= packed_word[23:0];
              bcnt <= bcnt + 2'd1;
              if (bcnt == 2'd3) begin
                byte_ready <= 1'b0;
                if (packed_word == chk) begin
                  state     <= DONE;
                  load_done <= 1'b1;
                  pc_clear  <= 1'b1;
                end else begin
                  state    <= ERR;
                  load_err <= 1'b1;
                end
              end
            end
          end
          ERR: ;
`endif
          DONE: begin
            state     <= RUN;
            cpu_stall <= 1'b0;
          end
          default: begin
            state      <= RUN;
            byte_ready <= 1'b0;
            cpu_stall  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
